ccd_capture_ctrl: RTL and testbench

Sequencer that drives the CCD readout timing feeding the ccd2axis line-to-AXI-Stream converter.
- Generates the shift-gate (sh) pulse and the per-line valid window that ccd2axis edge-detects.
- Paces lines at a programmable period and counts rows per frame.
- Supports single-shot and continuous capture.
- Flags downstream back-pressure during the effective-pixel window, because ccd2axis has no buffering.

---
 rtl/ccd_pkg.sv | 32 +++
 rtl/ccd_line_timer.sv | 107 ++++++++++
 rtl/ccd_capture_ctrl.sv | 127 ++++++++++++
 tb/tb_ccd_capture_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD readout sequencer: state encoding,
// default line geometry (common with ccd2axis) and derived timing helpers.
package ccd_pkg;

  // Line sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SH     = 3'd1,
    ST_GAP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_WAIT   = 3'd4
  } ccd_state_t;

  // Default sensor line geometry, also used by ccd2axis
  localparam int DEF_PRE_DUMMY_COLS  = 32;
  localparam int DEF_EFFECT_COLS     = 2048;
  localparam int DEF_POST_DUMMY_COLS = 8;

  // Pixels clocked out per line, dummies included
  function automatic int ccd_total(input int pre_cols, input int effect_cols,
                                   input int post_cols);
    return pre_cols + effect_cols + post_cols;
  endfunction

  // Shortest legal line period: sh + gap + window + one low cycle so the
  // consumer always sees a fresh rising edge of line_valid
  function automatic int ccd_min_period(input int sh_width, input int sh_gap,
                                        input int total);
    return sh_width + sh_gap + total + 1;
  endfunction

endpackage

// File: rtl/ccd_line_timer.sv
// One-line timing engine: on go it emits the sh pulse, the gap, the
// line_valid window with its column count, then idles out the period.
// line_end marks the last cycle of the period; line_end_soon the one before.
module ccd_line_timer
  import ccd_pkg::*;
#(
  parameter int TOTAL    = ccd_total(DEF_PRE_DUMMY_COLS, DEF_EFFECT_COLS, DEF_POST_DUMMY_COLS),
  parameter int SH_WIDTH = 16,
  parameter int SH_GAP   = 4,
  parameter int PCNT_W   = 17,
  parameter int COL_W    = 12
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              go,
  input  logic [PCNT_W-1:0] period_m1,
  output logic              sh,
  output logic              line_valid,
  output logic              busy,
  output logic [COL_W-1:0]  col,
  output logic              line_end,
  output logic              line_end_soon
);

  localparam logic [PCNT_W-1:0] SH_LAST  = PCNT_W'(SH_WIDTH - 1);
  localparam logic [PCNT_W-1:0] GAP_LAST = PCNT_W'(SH_WIDTH + SH_GAP - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(TOTAL - 1);

  ccd_state_t        state_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic [COL_W-1:0]  col_reg;
  logic              sh_reg;
  logic              line_valid_reg;
  logic              busy_reg;

  // Line FSM; outputs are set on the same edge as the state they belong to
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pcnt_reg       <= '0;
      col_reg        <= '0;
      sh_reg         <= 1'b0;
      line_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_reg + PCNT_W'(1);
      unique case (state_reg)
        ST_IDLE: begin
          pcnt_reg <= '0;
          if (go) begin
            state_reg <= ST_SH;
            sh_reg    <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        ST_SH: begin
          if (pcnt_reg == SH_LAST) begin
            state_reg <= ST_GAP;
            sh_reg    <= 1'b0;
          end
        end
        ST_GAP: begin
          if (pcnt_reg == GAP_LAST) begin
            state_reg      <= ST_ACTIVE;
            line_valid_reg <= 1'b1;
            col_reg        <= '0;
          end
        end
        ST_ACTIVE: begin
          col_reg <= col_reg + COL_W'(1);
          if (col_reg == COL_LAST) begin
            state_reg      <= ST_WAIT;
            line_valid_reg <= 1'b0;
            col_reg        <= '0;
          end
        end
        ST_WAIT: begin
          if (pcnt_reg == period_m1) begin
            pcnt_reg <= '0;
            if (go) begin
              state_reg <= ST_SH;
              sh_reg    <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          sh_reg         <= 1'b0;
          line_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign sh            = sh_reg;
  assign line_valid    = line_valid_reg;
  assign busy          = busy_reg;
  assign col           = col_reg;
  assign line_end      = (state_reg == ST_WAIT) && (pcnt_reg == period_m1);
  // pcnt only passes P-2 once per line, and always inside ACTIVE or WAIT
  assign line_end_soon = (state_reg != ST_IDLE) && (pcnt_reg == period_m1 - PCNT_W'(1));

endmodule

// File: rtl/ccd_capture_ctrl.sv
// CCD capture sequencer: latches capture config on start, counts rows,
// handles deferred stop and flags back-pressure inside the effective window.
module ccd_capture_ctrl
  import ccd_pkg::*;
#(
  parameter int PRE_DUMMY_COLS  = DEF_PRE_DUMMY_COLS,
  parameter int EFFECT_COLS     = DEF_EFFECT_COLS,
  parameter int POST_DUMMY_COLS = DEF_POST_DUMMY_COLS,
  parameter int SH_WIDTH        = 16,
  parameter int SH_GAP          = 4,
  parameter int PERIOD_W        = 16
) (
  input  logic                pixel_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [PERIOD_W-1:0] line_period,
  input  logic [10:0]         rows,
  input  logic                m_axis_tready,
  output logic                sh,
  output logic                line_valid,
  output logic                busy,
  output logic [10:0]         row_index,
  output logic                frame_done,
  output logic                overflow
);

  localparam int TOTAL      = ccd_total(PRE_DUMMY_COLS, EFFECT_COLS, POST_DUMMY_COLS);
  localparam int MIN_PERIOD = ccd_min_period(SH_WIDTH, SH_GAP, TOTAL);
  localparam int PCNT_W     = PERIOD_W + 1;
  localparam int COL_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [PCNT_W-1:0] MIN_P  = PCNT_W'(MIN_PERIOD);
  localparam logic [COL_W:0]    EFF_LO = (COL_W + 1)'(PRE_DUMMY_COLS);
  localparam logic [COL_W:0]    EFF_HI = (COL_W + 1)'(PRE_DUMMY_COLS + EFFECT_COLS);

  logic              continuous_reg;
  logic [PCNT_W-1:0] period_m1_reg;
  logic [10:0]       rows_m1_reg;
  logic [10:0]       row_index_reg;
  logic              stop_pend_reg;
  logic              frame_done_reg;
  logic              overflow_reg;

  logic              line_end;
  logic              line_end_soon;
  logic [COL_W-1:0]  col;
  logic              accept;
  logic              last_row;
  logic              go;
  logic              in_eff;
  logic [PCNT_W-1:0] period_ext;
  logic [PCNT_W-1:0] period_eff;

  assign accept     = !busy && start && !stop;
  assign last_row   = (row_index_reg == rows_m1_reg);
  assign go         = accept ||
                      (line_end && !stop_pend_reg && (!last_row || continuous_reg));
  assign period_ext = {1'b0, line_period};
  assign period_eff = (period_ext < MIN_P) ? MIN_P : period_ext;
  assign in_eff     = ({1'b0, col} >= EFF_LO) && ({1'b0, col} < EFF_HI);

  ccd_line_timer #(
    .TOTAL    (TOTAL),
    .SH_WIDTH (SH_WIDTH),
    .SH_GAP   (SH_GAP),
    .PCNT_W   (PCNT_W),
    .COL_W    (COL_W)
  ) u_line_timer (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .go            (go),
    .period_m1     (period_m1_reg),
    .sh            (sh),
    .line_valid    (line_valid),
    .busy          (busy),
    .col           (col),
    .line_end      (line_end),
    .line_end_soon (line_end_soon)
  );

  // Capture configuration is frozen for the whole capture once accepted
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      continuous_reg <= 1'b0;
      period_m1_reg  <= MIN_P - PCNT_W'(1);
      rows_m1_reg    <= '0;
    end else if (accept) begin
      continuous_reg <= continuous;
      period_m1_reg  <= period_eff - PCNT_W'(1);
      rows_m1_reg    <= (rows == 11'd0) ? 11'd0 : rows - 11'd1;
    end
  end

  // Row counting, deferred stop and the frame_done pulse. frame_done is
  // decided one cycle early so it lands on the last cycle of the frame;
  // including the live stop keeps it consistent with stop_pend at line_end.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      row_index_reg  <= '0;
      stop_pend_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= line_end_soon && last_row && !(stop_pend_reg || stop);
      if (accept) begin
        row_index_reg <= '0;
      end else if (line_end) begin
        if (stop_pend_reg || last_row) row_index_reg <= '0;
        else                           row_index_reg <= row_index_reg + 11'd1;
      end
      if (line_end && !go)    stop_pend_reg <= 1'b0;
      else if (busy && stop)  stop_pend_reg <= 1'b1;
    end
  end

  // Sticky overflow: consumer stalled while real pixels were on the bus
  always_ff @(posedge pixel_clk) begin
    if (rst || accept)                          overflow_reg <= 1'b0;
    else if (line_valid && in_eff && !m_axis_tready) overflow_reg <= 1'b1;
  end

  assign row_index  = row_index_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// Directed bench for ccd_capture_ctrl with a small line geometry
// (TOTAL=12, MIN_PERIOD=18). Offsets count samples after the start edge:
// offset k is the negedge sample following the (k-1)th edge after start.
module tb_ccd_capture_ctrl;

  localparam int PW     = 16;
  localparam int BUDGET = 200;

  logic          pixel_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [PW-1:0] line_period = '0;
  logic [10:0]   rows = '0;
  logic          m_axis_tready = 1'b1;
  logic          sh, line_valid, busy, frame_done, overflow;
  logic [10:0]   row_index;

  ccd_capture_ctrl #(
    .PRE_DUMMY_COLS  (2),
    .EFFECT_COLS     (8),
    .POST_DUMMY_COLS (2),
    .SH_WIDTH        (3),
    .SH_GAP          (2),
    .PERIOD_W        (PW)
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .line_period   (line_period),
    .rows          (rows),
    .m_axis_tready (m_axis_tready),
    .sh            (sh),
    .line_valid    (line_valid),
    .busy          (busy),
    .row_index     (row_index),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    string name;
    int    rows;
    int    period;
    int    cont;
    int    stop_off;   // offset at which stop is pulsed (0 = never)
    int    rdy_off;    // offset at which tready drops for one cycle (0 = never)
    int    rs_off;     // offset of an extra start with different config (0 = never)
    int    e_sh;       // sh pulses
    int    e_lv;       // line_valid windows
    int    e_sp;       // first sh-to-sh spacing (0 = single line)
    int    e_gap;      // low cycles between first two windows (0 = single line)
    int    e_fd;       // frame_done pulses
    int    e_fdo;      // offset of first frame_done (0 = none)
    int    e_bf;       // offset where busy is first seen low
    int    e_mr;       // highest row_index seen
    int    e_ovf;      // overflow at the end of the run
  } vec_t;

  vec_t vecs[11];

  int checks = 0;
  int errors = 0;

  int r_sh, r_sh_hi, r_lv, r_lv_hi, r_lv_first, r_sp, r_gap;
  int r_fd, r_fdo, r_bf, r_mr, r_ovf1, r_ovf, r_row_end;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Start a capture with the vector's config and record its outputs until busy drops
  task automatic run_vec(input vec_t v);
    int first_sh = 0;
    int lv_fall = 0;
    bit prev_sh = 1'b0;
    bit prev_lv = 1'b0;
    r_sh = 0; r_sh_hi = 0; r_lv = 0; r_lv_hi = 0; r_lv_first = 0; r_sp = 0;
    r_gap = 0; r_fd = 0; r_fdo = 0; r_bf = 0; r_mr = 0; r_ovf1 = 0;
    @(negedge pixel_clk);
    rows        = 11'(v.rows);
    line_period = PW'(v.period);
    continuous  = (v.cont != 0);
    start       = 1'b1;
    for (int off = 1; off <= BUDGET; off++) begin
      @(negedge pixel_clk);
      start = 1'b0;
      stop = 1'b0;
      m_axis_tready = 1'b1;
      if (sh && !prev_sh) begin
        r_sh++;
        if (r_sh == 1) first_sh = off;
        else if (r_sh == 2) r_sp = off - first_sh;
      end
      if (sh) r_sh_hi++;
      if (line_valid && !prev_lv) begin
        r_lv++;
        if (r_lv == 1) r_lv_first = off;
        else if (r_lv == 2) r_gap = off - lv_fall;
      end
      if (!line_valid && prev_lv) lv_fall = off;
      if (line_valid) r_lv_hi++;
      if (frame_done) begin
        r_fd++;
        if (r_fd == 1) r_fdo = off;
      end
      if (int'(row_index) > r_mr) r_mr = int'(row_index);
      if (off == 1) r_ovf1 = int'(overflow);
      prev_sh = sh;
      prev_lv = line_valid;
      if (!busy) begin
        r_bf = off;
        break;
      end
      if (off == v.stop_off) stop = 1'b1;
      if (off == v.rdy_off)  m_axis_tready = 1'b0;
      if (off == v.rs_off) begin
        start       = 1'b1;
        rows        = 11'd5;
        line_period = PW'(40);
        continuous  = 1'b1;
      end
    end
    r_ovf     = int'(overflow);
    r_row_end = int'(row_index);
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".sh_cnt"},    r_sh,       v.e_sh);
    chk({v.name, ".sh_cycles"}, r_sh_hi,    3 * v.e_sh);
    chk({v.name, ".lv_cnt"},    r_lv,       v.e_lv);
    chk({v.name, ".lv_cycles"}, r_lv_hi,    12 * v.e_lv);
    chk({v.name, ".lv_first"},  r_lv_first, 6);
    chk({v.name, ".sh_space"},  r_sp,       v.e_sp);
    chk({v.name, ".lv_gap"},    r_gap,      v.e_gap);
    chk({v.name, ".fd_cnt"},    r_fd,       v.e_fd);
    chk({v.name, ".fd_off"},    r_fdo,      v.e_fdo);
    chk({v.name, ".busy_fall"}, r_bf,       v.e_bf);
    chk({v.name, ".max_row"},   r_mr,       v.e_mr);
    chk({v.name, ".row_end"},   r_row_end,  0);
    chk({v.name, ".ovf_start"}, r_ovf1,     0);
    chk({v.name, ".ovf_end"},   r_ovf,      v.e_ovf);
    $display("vec %s: sh=%0d lv=%0d space=%0d gap=%0d fd=%0d@%0d busy_fall=%0d ovf=%0d",
             v.name, r_sh, r_lv, r_sp, r_gap, r_fd, r_fdo, r_bf, r_ovf);
  endtask

  task automatic chk_all_low(input string name);
    chk({name, ".sh"},         int'(sh),         0);
    chk({name, ".line_valid"}, int'(line_valid), 0);
    chk({name, ".busy"},       int'(busy),       0);
    chk({name, ".row_index"},  int'(row_index),  0);
    chk({name, ".frame_done"}, int'(frame_done), 0);
    chk({name, ".overflow"},   int'(overflow),   0);
  endtask

  initial begin
    //               name               rows per  cont stop rdy rs  sh lv sp  gap fd fdo bf  mr ovf
    vecs[0]  = '{"single",            2,  30, 0,   0,  0,  0, 2, 2, 30, 18, 1, 60, 61, 1, 0};
    vecs[1]  = '{"clamp_single",      1,   5, 0,   0,  0,  0, 1, 1,  0,  0, 1, 18, 19, 0, 0};
    vecs[2]  = '{"clamp_cont",        1,   5, 1,  40,  0,  0, 3, 3, 18,  6, 2, 18, 55, 0, 0};
    vecs[3]  = '{"rows_zero",         0,  20, 0,   0,  0,  0, 1, 1,  0,  0, 1, 20, 21, 0, 0};
    vecs[4]  = '{"cont_stop",         3,  20, 1,  28,  0,  0, 2, 2, 20,  8, 0,  0, 41, 1, 0};
    vecs[5]  = '{"ovf_pre_dummy",     1,  20, 0,   0,  7,  0, 1, 1,  0,  0, 1, 20, 21, 0, 0};
    vecs[6]  = '{"ovf_first_eff",     1,  20, 0,   0,  8,  0, 1, 1,  0,  0, 1, 20, 21, 0, 1};
    vecs[7]  = '{"ovf_post_dummy",    1,  20, 0,   0, 16,  0, 1, 1,  0,  0, 1, 20, 21, 0, 0};
    vecs[8]  = '{"ovf_last_eff",      1,  20, 0,   0, 15,  0, 1, 1,  0,  0, 1, 20, 21, 0, 1};
    vecs[9]  = '{"ovf_sticky_cont",   1,  20, 1,  30, 11,  0, 2, 2, 20,  8, 1, 20, 41, 0, 1};
    vecs[10] = '{"restart_ignored",   1,  20, 0,   0,  0,  8, 1, 1,  0,  0, 1, 20, 21, 0, 0};

    // Reset state
    repeat (3) @(negedge pixel_clk);
    chk_all_low("reset");
    $display("reset: sh=%0d lv=%0d busy=%0d row=%0d", sh, line_valid, busy, row_index);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      check_vec(vecs[i]);
    end

    // start and stop in the same idle cycle: stop wins
    @(negedge pixel_clk);
    rows = 11'd2; line_period = PW'(30); continuous = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge pixel_clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop.busy1", int'(busy), 0);
    chk("start_stop.sh1",   int'(sh),   0);
    repeat (3) @(negedge pixel_clk);
    chk("start_stop.busy4", int'(busy), 0);
    $display("start_stop: busy=%0d sh=%0d", busy, sh);

    // Reset during the ACTIVE window of row 1 (offset 40 of a P=30 capture)
    @(negedge pixel_clk);
    rows = 11'd2; line_period = PW'(30); continuous = 1'b0; start = 1'b1;
    for (int off = 1; off <= 40; off++) begin
      @(negedge pixel_clk);
      start = 1'b0;
    end
    chk("midline.lv_before",  int'(line_valid), 1);
    chk("midline.row_before", int'(row_index),  1);
    rst = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b0;
    chk_all_low("midline_reset");
    $display("midline_reset: sh=%0d lv=%0d busy=%0d row=%0d fd=%0d ovf=%0d",
             sh, line_valid, busy, row_index, frame_done, overflow);

    run_vec(vecs[0]);
    check_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
